// File: rtl/fib_mem_reader_if.sv
// Memory read port and output stream of the Fibonacci readback stage.
// The master side is the reader; the slave side is memory plus the downstream consumer.
interface fib_mem_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_rd_en, mem_addr, out_data, out_index, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, out_data, out_index, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/fib_mem_reader.sv
// Reads n stored Fibonacci terms back from memory, streams them out on valid/ready,
// and flags the first term that breaks the recurrence.
module fib_mem_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int CHECK_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n,
    input  logic              fib_ready,
    fib_mem_reader_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_index
);
    typedef enum logic [2:0] {
        IDLE, WAIT_GEN, RD, WAIT_D, PRESENT, FIN
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] n_q_reg;
    logic [DATA_W-1:0] prev1_reg;
    logic [DATA_W-1:0] prev2_reg;
    logic              mem_rd_en_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [ADDR_W-1:0] out_index_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] err_index_reg;

    logic [DATA_W-1:0] want_next;
    logic              mismatch;

    // Term the recurrence predicts for the current index; the sum wraps at DATA_W.
    always_comb begin
        want_next = prev1_reg + prev2_reg;
        if (idx_reg == '0)
            want_next = '0;
        else if (idx_reg == ADDR_W'(1))
            want_next = DATA_W'(1);
    end

    generate
        if (CHECK_EN != 0) begin : g_check
            assign mismatch = (bus.mem_rdata != want_next);
        end else begin : g_no_check
            assign mismatch = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            n_q_reg       <= '0;
            prev1_reg     <= '0;
            prev2_reg     <= '0;
            mem_rd_en_reg <= 1'b0;
            mem_addr_reg  <= '0;
            out_data_reg  <= '0;
            out_index_reg <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_index_reg <= '0;
        end else begin
            mem_rd_en_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_q_reg       <= n;
                        idx_reg       <= '0;
                        prev1_reg     <= '0;
                        prev2_reg     <= '0;
                        err_reg       <= 1'b0;
                        err_index_reg <= '0;
                        busy_reg      <= 1'b1;
                        if (n == '0) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else if (fib_ready) begin
                            state_reg     <= RD;
                            mem_rd_en_reg <= 1'b1;
                            mem_addr_reg  <= '0;
                        end else begin
                            state_reg <= WAIT_GEN;
                        end
                    end
                end
                WAIT_GEN: begin
                    if (fib_ready) begin
                        state_reg     <= RD;
                        mem_rd_en_reg <= 1'b1;
                        mem_addr_reg  <= idx_reg;
                    end
                end
                RD: state_reg <= WAIT_D;
                WAIT_D: begin
                    out_data_reg  <= bus.mem_rdata;
                    out_index_reg <= idx_reg;
                    out_valid_reg <= 1'b1;
                    // History follows the stored terms, so one bad term can trip later checks too.
                    prev2_reg     <= prev1_reg;
                    prev1_reg     <= bus.mem_rdata;
                    if (mismatch && !err_reg) begin
                        err_reg       <= 1'b1;
                        err_index_reg <= idx_reg;
                    end
                    state_reg <= PRESENT;
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (idx_reg == n_q_reg - ADDR_W'(1)) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg       <= idx_reg + ADDR_W'(1);
                            state_reg     <= RD;
                            mem_rd_en_reg <= 1'b1;
                            mem_addr_reg  <= idx_reg + ADDR_W'(1);
                        end
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_index = out_index_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign err_index     = err_index_reg;
endmodule

// File: tb/tb_fib_mem_reader.sv
// Directed and randomized readback runs against a memory model and a recurrence
// reference computed from the memory contents.
module tb_fib_mem_reader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] n;
    logic              fib_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_index;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [64];

    fib_mem_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fib_mem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHECK_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (n),
        .fib_ready (fib_ready),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    // Memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        mem[0] = '0;
        mem[1] = 32'd1;
        for (int i = 2; i < 64; i++)
            mem[i] = mem[i-1] + mem[i-2];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'(0));
        chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(0));
        chk({tag, "_data"}, 64'(bus.out_data), 64'(0));
        chk({tag, "_index"}, 64'(bus.out_index), 64'(0));
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_err_index"}, 64'(err_index), 64'(0));
    endtask

    // One complete run; expectations come from the memory contents and the recurrence rules.
    task automatic do_run(input string name, input int nn, input int gen_delay, input int ready_pct,
                          input int stall_idx, input int stall_len, input bit noise);
        logic [DATA_W-1:0] want;
        int exp_err, exp_eidx, beat, rd_cnt, cyc, first_rd, first_val, last_hs, stall_cnt;
        bit done_seen, rdy;
        exp_err = 0;
        exp_eidx = 0;
        for (int i = 0; i < nn; i++) begin
            want = (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : mem[i-1] + mem[i-2];
            if (mem[i] != want && exp_err == 0) begin
                exp_err = 1;
                exp_eidx = i;
            end
        end
        @(negedge clk);
        start = 1'b1;
        n = ADDR_W'(nn);
        fib_ready = (gen_delay == 0);
        out_ready_drive(1'b0);
        cyc = 0; first_rd = -1; first_val = -1; last_hs = -1;
        beat = 0; rd_cnt = 0; stall_cnt = 0; done_seen = 0;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (noise) begin
                start = 1'($urandom_range(1));
                n = ADDR_W'($urandom);
            end else begin
                start = 1'b0;
            end
            chk({name, "_busy"}, 64'(busy), 64'(1));
            if (cyc <= gen_delay)
                chk({name, "_no_rd_while_gen"}, 64'(bus.mem_rd_en), 64'(0));
            if (cyc == gen_delay)
                fib_ready = 1'b1;
            else if (noise && cyc > gen_delay)
                fib_ready = 1'($urandom_range(1));
            if (bus.mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk({name, "_addr"}, 64'(bus.mem_addr), 64'(rd_cnt));
                rd_cnt++;
            end
            if (bus.out_valid) begin
                if (first_val < 0) first_val = cyc;
                chk({name, "_rd_vs_valid"}, 64'(bus.mem_rd_en), 64'(0));
                chk({name, "_index"}, 64'(bus.out_index), 64'(beat));
                chk({name, "_data"}, 64'(bus.out_data), 64'(mem[beat]));
                if (beat == stall_idx && stall_cnt < stall_len) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    rdy = ($urandom_range(99) < ready_pct);
                end
                out_ready_drive(rdy);
                if (rdy) begin
                    if (ready_pct == 100 && stall_idx < 0 && last_hs >= 0)
                        chk({name, "_beat_spacing"}, 64'(cyc - last_hs), 64'(3));
                    last_hs = cyc;
                    beat++;
                end
            end else begin
                out_ready_drive(1'($urandom_range(1)));
            end
            if (done) done_seen = 1;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 64'(done_seen), 64'(1));
        chk({name, "_beats"}, 64'(beat), 64'(nn));
        chk({name, "_reads"}, 64'(rd_cnt), 64'(nn));
        chk({name, "_err"}, 64'(err), 64'(exp_err));
        chk({name, "_err_index"}, 64'(err_index), 64'(exp_eidx));
        if (nn > 0) begin
            chk({name, "_first_rd"}, 64'(first_rd), 64'(gen_delay + 1));
            chk({name, "_first_valid"}, 64'(first_val), 64'(first_rd + 2));
        end else begin
            chk({name, "_done_latency"}, 64'(cyc), 64'(1));
            chk({name, "_no_valid"}, 64'(first_val), 64'(-1));
        end
        if (stall_idx >= 0 && stall_idx < nn)
            chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(stall_len));
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'(0));
        chk({name, "_idle"}, 64'(busy), 64'(0));
        chk({name, "_err_sticky"}, 64'(err), 64'(exp_err));
        $display("run %s n=%0d beats=%0d reads=%0d err=%0d err_index=%0d", name, nn, beat, rd_cnt, err, err_index);
    endtask

    task automatic out_ready_drive(input logic v);
        bus.out_ready = v;
    endtask

    initial begin
        int nn, k;
        bit found;
        fill_mem();
        rst = 1'b0;
        start = 1'b0;
        n = '0;
        fib_ready = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        do_run("basic", 8, 0, 100, -1, 0, 1'b0);
        do_run("gen_wait", 5, 10, 100, -1, 0, 1'b0);
        do_run("backpressure", 8, 0, 100, 3, 4, 1'b0);
        mem[4] = 32'd7;
        do_run("corrupt", 8, 0, 100, -1, 0, 1'b0);
        fill_mem();
        do_run("n_zero", 0, 0, 100, -1, 0, 1'b0);

        // Reset while term 2 is presented, with an error already latched.
        mem[1] = 32'd5;
        @(negedge clk);
        start = 1'b1;
        n = ADDR_W'(8);
        fib_ready = 1'b1;
        bus.out_ready = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus.out_ready = 1'b1;
            if (bus.out_valid && bus.out_index == ADDR_W'(2)) found = 1;
        end
        chk("midrun_reached_term2", 64'(found), 64'(1));
        chk("midrun_err_before_rst", 64'(err), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrun_rst");
        rst = 1'b1;
        fill_mem();
        do_run("after_rst", 8, 0, 100, -1, 0, 1'b0);

        do_run("max_n", 63, 0, 100, -1, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            nn = $urandom_range(40, 1);
            if ($urandom_range(1) == 1) begin
                k = $urandom_range(nn - 1, 0);
                mem[k] = mem[k] ^ (32'd1 << $urandom_range(31, 0));
            end
            do_run($sformatf("random%0d", r), nn, $urandom_range(5, 0), $urandom_range(100, 30), -1, 0, 1'b1);
            fill_mem();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
